// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response plus the registered IF/ID payload.
// Master is the fetch stage; slave is the memory/decode side.
interface fetch_stage_if;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_read;
  logic [15:0] imem_address;
  logic [15:0] imem_rdata;
  logic        imem_resp;
  logic        if_valid;
  logic [15:0] if_pc;
  logic [15:0] if_ir;
  logic [3:0]  if_opcode;
  logic [11:0] if_irbits;

  modport master (
    input  stall, redirect_valid, redirect_pc, imem_rdata, imem_resp,
    output imem_read, imem_address, if_valid, if_pc, if_ir, if_opcode, if_irbits
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, imem_rdata, imem_resp,
    input  imem_read, imem_address, if_valid, if_pc, if_ir, if_opcode, if_irbits
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: one request per cycle with 1-cycle memory, one-entry skid on stall,
// redirect squashes output and flushes any outstanding request before refetching.
module fetch_stage (
  input  logic          clk_i,
  input  logic          reset_i,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {FETCH, HOLD, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] skid_q, skid_d;
  logic [15:0] skid_pc_q, skid_pc_d;
  logic [15:0] pend_addr_q, pend_addr_d;
  logic        vld_q, vld_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] out_pc_q, out_pc_d;
  logic        read_raw;
  logic [15:0] pc_inc;
  logic [15:0] redir_pc;

  assign pc_inc   = pc_q + 16'd2;
  assign redir_pc = {bus.redirect_pc[15:1], 1'b0};

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    skid_d           = skid_q;
    skid_pc_d        = skid_pc_q;
    pend_addr_d      = pend_addr_q;
    vld_d            = vld_q;
    ir_d             = ir_q;
    out_pc_d         = out_pc_q;
    read_raw         = 1'b0;
    bus.imem_address = pc_q;

    case (state_q)
      FETCH: begin
        read_raw    = 1'b1;
        pend_addr_d = pc_q;
        if (bus.redirect_valid) begin
          pc_d    = redir_pc;
          vld_d   = 1'b0;
          state_d = bus.imem_resp ? FETCH : FLUSH;
        end else if (bus.imem_resp) begin
          pc_d = pc_inc;
          if (bus.stall) begin
            skid_d    = bus.imem_rdata;
            skid_pc_d = pc_inc;
            state_d   = HOLD;
          end else begin
            vld_d    = 1'b1;
            ir_d     = bus.imem_rdata;
            out_pc_d = pc_inc;
          end
        end else if (!bus.stall) begin
          vld_d = 1'b0;
        end
      end

      HOLD: begin
        if (bus.redirect_valid) begin
          pc_d    = redir_pc;
          vld_d   = 1'b0;
          skid_d  = 16'h0000;
          state_d = FETCH;
        end else if (!bus.stall) begin
          vld_d    = 1'b1;
          ir_d     = skid_q;
          out_pc_d = skid_pc_q;
          state_d  = FETCH;
        end
      end

      FLUSH: begin
        // Hold the stale address until memory completes; its data is dropped.
        read_raw         = 1'b1;
        bus.imem_address = pend_addr_q;
        if (bus.redirect_valid) pc_d = redir_pc;
        if (bus.redirect_valid || !bus.stall) vld_d = 1'b0;
        if (bus.imem_resp) state_d = FETCH;
      end

      default: state_d = FETCH;
    endcase
  end

  assign bus.imem_read = read_raw & ~reset_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= FETCH;
      pc_q        <= 16'h0000;
      skid_q      <= 16'h0000;
      skid_pc_q   <= 16'h0000;
      pend_addr_q <= 16'h0000;
      vld_q       <= 1'b0;
      ir_q        <= 16'h0000;
      out_pc_q    <= 16'h0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      skid_q      <= skid_d;
      skid_pc_q   <= skid_pc_d;
      pend_addr_q <= pend_addr_d;
      vld_q       <= vld_d;
      ir_q        <= ir_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign bus.if_valid  = vld_q;
  assign bus.if_pc     = out_pc_q;
  assign bus.if_ir     = ir_q;
  assign bus.if_opcode = ir_q[15:12];
  assign bus.if_irbits = ir_q[11:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory, queue-based delivery model, directed + random stimulus.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:32767];
  int          lat_mode;
  int          lat;
  int          wait_cnt;

  // Model: instructions fetched but not yet presented, in program order.
  logic [31:0] m_q[$];
  logic        m_vld;
  logic [15:0] m_out_pc;
  logic [15:0] m_ir;
  logic [15:0] m_pc;
  logic [15:0] m_pend;
  bit          m_discard;

  logic        last_read;
  logic [15:0] last_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick_lat();
    return (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
  endfunction

  task automatic model_update(input bit r, input bit s, input bit rv, input logic [15:0] rpc,
                              input bit rd, input bit resp, input logic [15:0] addr,
                              input logic [15:0] data);
    logic [31:0] e;
    logic [15:0] nxt;
    if (r) begin
      m_vld = 1'b0; m_out_pc = 16'h0; m_ir = 16'h0; m_pc = 16'h0;
      m_q.delete(); m_discard = 1'b0;
    end else begin
      if (rd && !resp) m_pend = addr;
      if (rv) begin
        m_vld = 1'b0;
        m_q.delete();
        m_discard = rd && !resp;
        m_pc = {rpc[15:1], 1'b0};
      end else begin
        if (rd && resp) begin
          if (m_discard) m_discard = 1'b0;
          else begin
            nxt = m_pc + 16'd2;
            m_q.push_back({nxt, data});
            m_pc = nxt;
          end
        end
        if (!s) begin
          if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_vld = 1'b1; m_out_pc = e[31:16]; m_ir = e[15:0];
          end else m_vld = 1'b0;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit rv, input logic [15:0] rpc);
    bit          exp_read;
    logic [15:0] exp_addr;
    bit          resp;
    @(negedge clk);
    reset              = r;
    bus.stall          = s;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.imem_resp      = 1'b0;
    bus.imem_rdata     = 16'($urandom);
    #1;
    exp_read  = !r && (m_q.size() == 0);
    exp_addr  = m_discard ? m_pend : m_pc;
    last_read = bus.imem_read;
    last_addr = bus.imem_address;
    chk("imem_read", {31'b0, bus.imem_read}, {31'b0, exp_read});
    if (exp_read) chk("imem_address", {16'b0, bus.imem_address}, {16'b0, exp_addr});
    resp = 1'b0;
    if (bus.imem_read) begin
      resp = (wait_cnt + 1 >= lat);
      bus.imem_resp = resp;
      if (resp) bus.imem_rdata = mem[bus.imem_address[15:1]];
    end
    if (bus.imem_read && resp) begin wait_cnt = 0; lat = pick_lat(); end
    else if (bus.imem_read) wait_cnt++;
    else wait_cnt = 0;
    model_update(r, s, rv, rpc, exp_read, exp_read && resp, exp_addr, bus.imem_rdata);
    @(posedge clk);
    #1;
    chk("if_valid", {31'b0, bus.if_valid}, {31'b0, m_vld});
    chk("if_pc", {16'b0, bus.if_pc}, {16'b0, m_out_pc});
    chk("if_ir", {16'b0, bus.if_ir}, {16'b0, m_ir});
    chk("if_opcode", {28'b0, bus.if_opcode}, {28'b0, m_ir[15:12]});
    chk("if_irbits", {20'b0, bus.if_irbits}, {20'b0, m_ir[11:0]});
  endtask

  task automatic do_reset(input int lm);
    lat_mode = lm;
    lat      = pick_lat();
    step(1, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0);
  endtask

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 16'h0;
    bus.imem_resp = 1'b0; bus.imem_rdata = 16'h0;
    m_discard = 1'b0; m_pend = 16'h0; m_pc = 16'h0;
    wait_cnt = 0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1261; mem[1] = 16'h5020; mem[2] = 16'h0E02;

    // Straight line, 1-cycle memory
    do_reset(1);
    chk("rst_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("rst_pc", {16'b0, bus.if_pc}, 32'h0);
    chk("rst_ir", {16'b0, bus.if_ir}, 32'h0);
    step(0, 0, 0, 16'h0);
    chk("line0_pc", {16'b0, bus.if_pc}, 32'h0002);
    chk("line0_op", {28'b0, bus.if_opcode}, 32'd1);
    step(0, 0, 0, 16'h0);
    chk("line1_pc", {16'b0, bus.if_pc}, 32'h0004);
    chk("line1_op", {28'b0, bus.if_opcode}, 32'd5);
    step(0, 0, 0, 16'h0);
    chk("line2_pc", {16'b0, bus.if_pc}, 32'h0006);
    chk("line2_ir", {16'b0, bus.if_ir}, 32'h0E02);
    chk("line2_vld", {31'b0, bus.if_valid}, 32'd1);

    // Stall for 3 cycles while the 0x0004 entry returns
    do_reset(1);
    step(0, 0, 0, 16'h0);
    step(0, 1, 0, 16'h0);
    chk("stall_hold_pc", {16'b0, bus.if_pc}, 32'h0002);
    step(0, 1, 0, 16'h0);
    chk("stall_noread", {31'b0, last_read}, 32'd0);
    step(0, 1, 0, 16'h0);
    chk("stall_hold_ir", {16'b0, bus.if_ir}, 32'h1261);
    step(0, 0, 0, 16'h0);
    chk("skid_pc", {16'b0, bus.if_pc}, 32'h0004);
    chk("skid_ir", {16'b0, bus.if_ir}, 32'h5020);
    step(0, 0, 0, 16'h0);
    chk("after_skid_pc", {16'b0, bus.if_pc}, 32'h0006);

    // Redirect during an outstanding 3-cycle request
    do_reset(3);
    step(0, 0, 0, 16'h0);
    step(0, 0, 1, 16'h3000);
    step(0, 0, 0, 16'h0);
    chk("flush_addr", {16'b0, last_addr}, 32'h0000);
    chk("flush_vld", {31'b0, bus.if_valid}, 32'd0);
    step(0, 0, 0, 16'h0);
    chk("redir_addr", {16'b0, last_addr}, 32'h3000);
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    chk("redir_pc", {16'b0, bus.if_pc}, 32'h3002);
    chk("redir_vld", {31'b0, bus.if_valid}, 32'd1);

    // Redirect while stalled with the skid occupied
    do_reset(1);
    step(0, 0, 0, 16'h0);
    step(0, 1, 0, 16'h0);
    step(0, 1, 1, 16'h5000);
    chk("hold_redir_vld", {31'b0, bus.if_valid}, 32'd0);
    step(0, 0, 0, 16'h0);
    chk("hold_redir_addr", {16'b0, last_addr}, 32'h5000);
    chk("hold_redir_pc", {16'b0, bus.if_pc}, 32'h5002);

    // Wrap and odd redirect target
    step(0, 0, 1, 16'hFFFE);
    step(0, 0, 0, 16'h0);
    chk("wrap_addr", {16'b0, last_addr}, 32'hFFFE);
    chk("wrap_pc", {16'b0, bus.if_pc}, 32'h0000);
    step(0, 0, 0, 16'h0);
    chk("wrap_next", {16'b0, last_addr}, 32'h0000);
    step(0, 0, 1, 16'h4001);
    step(0, 0, 0, 16'h0);
    chk("odd_addr", {16'b0, last_addr}, 32'h4000);

    // Reset during FLUSH
    do_reset(3);
    step(0, 0, 0, 16'h0);
    step(0, 0, 1, 16'h3000);
    step(1, 0, 0, 16'h0);
    chk("rflush_noread", {31'b0, last_read}, 32'd0);
    chk("rflush_vld", {31'b0, bus.if_valid}, 32'd0);
    step(0, 0, 0, 16'h0);
    chk("rflush_read", {31'b0, last_read}, 32'd1);
    chk("rflush_addr", {16'b0, last_addr}, 32'h0000);

    // Random traffic with mixed latency
    do_reset(0);
    for (int n = 0; n < 3000; n++) begin
      bit          r, s, rv;
      logic [15:0] rpc;
      r   = ($urandom_range(0, 99) < 1);
      s   = ($urandom_range(0, 99) < 30);
      rv  = ($urandom_range(0, 99) < 5);
      rpc = 16'($urandom);
      if ($urandom_range(0, 9) == 0) rpc = {15'h7FFF, rpc[0]};
      step(r, s, rv, rpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have stall  in  1  decode/IF-ID not accepting; freezes output register.
REQ-004 SHALL have redirect_valid  in  1  taken branch/jump/trap from a later stage; squash and refetch.
REQ-005 SHALL have redirect_pc  in  16  target byte address.
REQ-006 SHALL have imem_read  out  1  instruction memory read request.
REQ-007 SHALL have imem_address  out  16  read address, word aligned.
REQ-008 SHALL have imem_rdata  in  16  returned instruction, valid with imem_resp.
REQ-009 SHALL have imem_resp  in  1  one-cycle read completion.
REQ-010 SHALL have if_valid, if_pc[15:0], if_ir[15:0], if_opcode[3:0], if_irbits[11:0]  out  registered IF/ID payload; if_pc = fetch address + 2; if_opcode = if_ir[15:12]; if_irbits = if_ir[11:0].

Function
REQ-011 SHALL implement states FETCH, HOLD, FLUSH; 16-bit pc register; 16-bit skid register plus skid_pc; 16-bit pend_addr register.
REQ-012 SHALL force bit 0 of every pc load (reset, increment, redirect) to 0; increment is +2 modulo 2^16 (0xFFFE wraps to 0x0000).
REQ-013 FETCH: SHALL drive imem_read=1, imem_address=pc, pend_addr<=pc; imem_read held high until imem_resp (memory protocol: request address stable until response).
REQ-014 FETCH, imem_resp=1, redirect_valid=0, stall=0: output <= {valid=1, ir=imem_rdata, pc=pc+2}; pc<=pc+2; stay FETCH; next request issued the following cycle (1-cycle response gives one instruction per cycle).
REQ-015 FETCH, imem_resp=1, redirect_valid=0, stall=1: output frozen; skid<=imem_rdata, skid_pc<=pc+2; pc<=pc+2; go HOLD.
REQ-016 FETCH, imem_resp=0, stall=0: output <= bubble (if_valid=0, if_ir and if_pc retain old value).
REQ-017 Any state, stall=1 and no redirect: if_valid/if_pc/if_ir SHALL NOT change.
REQ-018 HOLD: imem_read=0; on stall=0 output<=skid contents with if_valid=1, go FETCH; on stall=1 remain HOLD.
REQ-019 redirect_valid=1 SHALL override stall: if_valid<=0 next cycle, skid discarded, pc<=redirect_pc.
REQ-020 redirect in FETCH with imem_resp=0: go FLUSH; in FLUSH imem_read=1, imem_address=pend_addr until imem_resp, response discarded, then go FETCH.
REQ-021 redirect in FETCH with imem_resp=1: response discarded, go FETCH (new address next cycle).
REQ-022 redirect in HOLD: go FETCH. Redirect in FLUSH: pc<=new redirect_pc, remain FLUSH (latest redirect wins).
REQ-023 No instruction SHALL ever be duplicated or dropped absent a redirect; program order preserved.

Reset
REQ-024 While reset=1: state<=FETCH, pc<=0x0000, if_valid<=0, if_ir<=0x0000, if_pc<=0x0000, skid cleared; imem_read=0 during reset cycles.
REQ-025 Reset asserted mid-request SHALL abandon it; first cycle after reset deassert SHALL issue imem_read=1, imem_address=0x0000.
REQ-026 Reset SHALL take priority over redirect_valid and stall.

Verification
REQ-027 Straight line: reset, memory returns 0x1261,0x5020,0x0E02 with 1-cycle resp, stall=0 -> if_pc 0x0002,0x0004,0x0006, if_opcode 1,5,0, if_valid every cycle.
REQ-028 Stall: assert stall 3 cycles while response for 0x0004 returns -> output holds 0x0002 entry, imem_read=0 in HOLD, then 0x0004 entry presented once stall drops, no duplicate/drop.
REQ-029 Redirect during outstanding request (3-cycle memory latency) to 0x3000 -> FLUSH holds old address until resp, data discarded, next request at 0x3000, first valid if_pc=0x3002.
REQ-030 Redirect with stall=1 and HOLD occupied -> if_valid=0 next cycle, skid lost, fetch at redirect_pc.
REQ-031 Wrap: redirect_pc=0xFFFE -> fetch 0xFFFE, if_pc=0x0000, next fetch 0x0000; odd redirect_pc 0x4001 -> fetch 0x4000.
REQ-032 Reset asserted during FLUSH -> next cycle state FETCH, if_valid=0, first request at 0x0000 after release.
